fetch_stage: RTL and testbench

Instruction fetch front end that drives the instruction-memory request port and feeds the decode stage. It holds the architectural fetch PC and issues one word-aligned read at a time. Returned words go into a small in-order instruction queue tagged with their current/next PC. Decode consumes from the head of the queue. A redirect from branch/jump resolution flushes the queue and restarts fetch at a new PC.

---
 rtl/fetch_stage.sv | 166 ++++++++++++++++
 tb/tb_fetch_stage.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch front end: owns the fetch PC, issues one word-aligned
// instruction-memory read at a time and buffers returned words, tagged with
// their PC and fall-through PC, in a small in-order queue read by decode.

package fetch_pkg;
    typedef struct packed {
        logic [31:0] fetch_pc_curr;
        logic [31:0] fetch_pc_next;
    } fetch_output_reg_t;
endpackage

module fetch_stage
    import fetch_pkg::*;
#(
    parameter int          QUEUE_DEPTH = 8,
    parameter logic [31:0] RESET_PC    = 32'h1eceb000
) (
    input  logic              clk,
    input  logic              rst,
    output logic [31:0]       imem_addr,
    output logic [3:0]        imem_rmask,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_resp,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    input  logic              deq,
    output logic              out_valid,
    output logic [31:0]       out_inst,
    output fetch_output_reg_t fetch_output
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] ST_REQ     = 2'd0;
    localparam logic [1:0] ST_FULL    = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc_curr;
        logic [31:0] pc_nxt;
    } entry_t;

    // Queue storage; the head is read combinationally so decode sees it
    // the cycle after the word is written.
    entry_t entry_mem [QUEUE_DEPTH];

    logic [31:0]      pc_reg, pc_next;
    logic [31:0]      addr_reg;
    logic [1:0]       state_reg, state_next;
    logic             bubble_reg, bubble_next;
    logic [PTR_W-1:0] head_reg, head_next;
    logic [PTR_W-1:0] tail_reg, tail_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [CNT_W-1:0] count_upd;

    logic requesting;
    logic enq;
    logic deq_eff;
    entry_t head_entry;

    // A fresh request is presented in REQ except in the post-response bubble.
    // addr_reg remembers the last presented address so the bus stays stable
    // through the bubble and while an abandoned request drains in DISCARD.
    always_comb begin
        requesting = (state_reg == ST_REQ) && !bubble_reg;
        imem_addr  = requesting ? pc_reg : addr_reg;
        imem_rmask = (requesting || (state_reg == ST_DISCARD)) ? 4'hF : 4'h0;
        enq        = requesting && imem_resp && !redirect_valid;
        deq_eff    = deq && (count_reg != '0) && !redirect_valid;
        count_upd  = count_reg + {{PTR_W{1'b0}}, enq} - {{PTR_W{1'b0}}, deq_eff};
    end

    // Queue head presentation to decode.
    always_comb begin
        head_entry                 = entry_mem[head_reg];
        out_valid                  = (count_reg != '0);
        out_inst                   = head_entry.inst;
        fetch_output.fetch_pc_curr = head_entry.pc_curr;
        fetch_output.fetch_pc_next = head_entry.pc_nxt;
    end

    // Next-state logic: redirect overrides everything else and flushes the queue.
    always_comb begin
        state_next  = state_reg;
        bubble_next = 1'b0;
        pc_next     = pc_reg;
        head_next   = head_reg;
        tail_next   = tail_reg;
        count_next  = count_reg;

        if (redirect_valid) begin
            pc_next    = redirect_pc & ~32'h3;
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
            case (state_reg)
                ST_REQ:     state_next = (requesting && !imem_resp) ? ST_DISCARD : ST_REQ;
                ST_FULL:    state_next = ST_REQ;
                ST_DISCARD: state_next = imem_resp ? ST_REQ : ST_DISCARD;
                default:    state_next = ST_REQ;
            endcase
        end else begin
            count_next = count_upd;
            if (enq) begin
                tail_next = tail_reg + PTR_W'(1);
            end
            if (deq_eff) begin
                head_next = head_reg + PTR_W'(1);
            end
            case (state_reg)
                ST_REQ: begin
                    if (enq) begin
                        pc_next = pc_reg + 32'd4;
                        if (count_upd < CNT_W'(QUEUE_DEPTH)) begin
                            bubble_next = 1'b1;
                        end else begin
                            state_next = ST_FULL;
                        end
                    end
                end
                ST_FULL: begin
                    if (count_upd < CNT_W'(QUEUE_DEPTH)) begin
                        state_next = ST_REQ;
                    end
                end
                ST_DISCARD: begin
                    if (imem_resp) begin
                        state_next = ST_REQ;
                    end
                end
                default: state_next = ST_REQ;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg     <= RESET_PC;
            addr_reg   <= RESET_PC;
            state_reg  <= ST_REQ;
            bubble_reg <= 1'b0;
            head_reg   <= '0;
            tail_reg   <= '0;
            count_reg  <= '0;
        end else begin
            pc_reg     <= pc_next;
            addr_reg   <= imem_addr;
            state_reg  <= state_next;
            bubble_reg <= bubble_next;
            head_reg   <= head_next;
            tail_reg   <= tail_next;
            count_reg  <= count_next;
        end
    end

    // Queue write: the returned word tagged with its PC and fall-through PC.
    always_ff @(posedge clk) begin
        if (!rst && enq) begin
            entry_mem[tail_reg] <= '{inst: imem_rdata, pc_curr: pc_reg, pc_nxt: pc_reg + 32'd4};
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: the memory side is driven by hand from the
// stimulus sequence, and each expected value is written out per step.

module tb_fetch_stage;
    import fetch_pkg::*;

    localparam logic [31:0] BASE = 32'h1eceb000;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       imem_addr;
    logic [3:0]        imem_rmask;
    logic [31:0]       imem_rdata;
    logic              imem_resp;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              deq;
    logic              out_valid;
    logic [31:0]       out_inst;
    fetch_output_reg_t fetch_output;

    int compared;
    int mismatched;

    fetch_stage #(.QUEUE_DEPTH(8), .RESET_PC(BASE)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rmask     (imem_rmask),
        .imem_rdata     (imem_rdata),
        .imem_resp      (imem_resp),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .deq            (deq),
        .out_valid      (out_valid),
        .out_inst       (out_inst),
        .fetch_output   (fetch_output)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hdeadbeef;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-14s observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        logic [31:0] a;
        compared       = 0;
        mismatched     = 0;
        rst            = 1'b1;
        imem_resp      = 1'b0;
        imem_rdata     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        deq            = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_rmask", {28'd0, imem_rmask}, 32'hF);
        chk("rst_addr",  imem_addr, BASE);

        // Streaming with deq held high and a same-cycle memory
        deq = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = BASE + 32'(4 * i);
            chk("t1_addr",  imem_addr, a);
            chk("t1_rmask", {28'd0, imem_rmask}, 32'hF);
            imem_resp  = 1'b1;
            imem_rdata = word_of(a);
            tick();
            imem_resp = 1'b0;
            chk("t1_bub_rmask", {28'd0, imem_rmask}, 32'h0);
            chk("t1_bub_addr",  imem_addr, a);
            chk("t1_valid",     {31'd0, out_valid}, 32'd1);
            chk("t1_inst",      out_inst, word_of(a));
            chk("t1_pc_curr",   fetch_output.fetch_pc_curr, a);
            chk("t1_pc_next",   fetch_output.fetch_pc_next, a + 32'd4);
            tick();
        end
        deq = 1'b0;
        chk("t1_drained", {31'd0, out_valid}, 32'd0);

        // Fill the queue with deq held low
        for (int i = 0; i < 8; i++) begin
            a = BASE + 32'd16 + 32'(4 * i);
            chk("t2_addr", imem_addr, a);
            imem_resp  = 1'b1;
            imem_rdata = word_of(a);
            tick();
            imem_resp = 1'b0;
            tick();
        end
        chk("t2_full_rmask", {28'd0, imem_rmask}, 32'h0);
        chk("t2_full_valid", {31'd0, out_valid}, 32'd1);
        chk("t2_full_head",  fetch_output.fetch_pc_curr, BASE + 32'd16);
        tick();
        chk("t2_full_hold",  {28'd0, imem_rmask}, 32'h0);
        deq = 1'b1;
        tick();
        deq = 1'b0;
        chk("t2_exit_rmask", {28'd0, imem_rmask}, 32'hF);
        chk("t2_exit_addr",  imem_addr, BASE + 32'h30);
        chk("t2_exit_head",  fetch_output.fetch_pc_curr, BASE + 32'd20);
        for (int j = 0; j < 6; j++) begin
            a = BASE + 32'd20 + 32'(4 * j);
            chk("t2_order_pc",   fetch_output.fetch_pc_curr, a);
            chk("t2_order_inst", out_inst, word_of(a));
            deq = 1'b1;
            tick();
            deq = 1'b0;
        end
        chk("t2_last_head", fetch_output.fetch_pc_curr, BASE + 32'd44);
        chk("t2_last_valid", {31'd0, out_valid}, 32'd1);
        chk("t2_outst_addr", imem_addr, BASE + 32'h30);

        // Redirect with a request outstanding and a late response
        redirect_valid = 1'b1;
        redirect_pc    = 32'h00001000;
        tick();
        redirect_valid = 1'b0;
        chk("t3_valid", {31'd0, out_valid}, 32'd0);
        chk("t3_addr",  imem_addr, BASE + 32'h30);
        chk("t3_rmask", {28'd0, imem_rmask}, 32'hF);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t3_hold_addr", imem_addr, BASE + 32'h30);
        end
        imem_resp  = 1'b1;
        imem_rdata = word_of(BASE + 32'h30);
        tick();
        imem_resp = 1'b0;
        chk("t3_drop_valid", {31'd0, out_valid}, 32'd0);
        chk("t3_new_addr",   imem_addr, 32'h00001000);
        chk("t3_new_rmask",  {28'd0, imem_rmask}, 32'hF);

        // Redirect in the same cycle as a response
        imem_resp  = 1'b1;
        imem_rdata = word_of(32'h00001000);
        tick();
        imem_resp = 1'b0;
        chk("t4_valid",   {31'd0, out_valid}, 32'd1);
        chk("t4_pc_curr", fetch_output.fetch_pc_curr, 32'h00001000);
        tick();
        chk("t4_addr", imem_addr, 32'h00001004);
        imem_resp      = 1'b1;
        imem_rdata     = word_of(32'h00001004);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h00003000;
        tick();
        imem_resp      = 1'b0;
        redirect_valid = 1'b0;
        chk("t4_rd_valid", {31'd0, out_valid}, 32'd0);
        chk("t4_rd_addr",  imem_addr, 32'h00003000);
        chk("t4_rd_rmask", {28'd0, imem_rmask}, 32'hF);
        tick();
        chk("t4_no_late", {31'd0, out_valid}, 32'd0);

        // Reset during an outstanding request, with a response during reset
        rst = 1'b1;
        tick();
        imem_resp  = 1'b1;
        imem_rdata = word_of(32'h00003000);
        tick();
        rst       = 1'b0;
        imem_resp = 1'b0;
        chk("t5_addr",  imem_addr, BASE);
        chk("t5_rmask", {28'd0, imem_rmask}, 32'hF);
        chk("t5_valid", {31'd0, out_valid}, 32'd0);
        tick();
        chk("t5_dropped", {31'd0, out_valid}, 32'd0);

        // deq on an empty queue must not underflow the count
        deq = 1'b1;
        tick();
        deq = 1'b0;
        chk("t6_empty_valid", {31'd0, out_valid}, 32'd0);
        imem_resp  = 1'b1;
        imem_rdata = word_of(BASE);
        tick();
        imem_resp = 1'b0;
        chk("t6_one_valid", {31'd0, out_valid}, 32'd1);
        chk("t6_one_inst",  out_inst, word_of(BASE));
        deq = 1'b1;
        tick();
        deq = 1'b0;
        chk("t6_zero_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_next_addr",  imem_addr, BASE + 32'd4);

        // Misaligned redirect target is word aligned
        redirect_valid = 1'b1;
        redirect_pc    = 32'h00002003;
        tick();
        redirect_valid = 1'b0;
        chk("t7_disc_addr", imem_addr, BASE + 32'd4);
        imem_resp  = 1'b1;
        imem_rdata = 32'h12345678;
        tick();
        imem_resp = 1'b0;
        chk("t7_addr",  imem_addr, 32'h00002000);
        chk("t7_rmask", {28'd0, imem_rmask}, 32'hF);
        imem_resp  = 1'b1;
        imem_rdata = word_of(32'h00002000);
        tick();
        imem_resp = 1'b0;
        chk("t7_valid",   {31'd0, out_valid}, 32'd1);
        chk("t7_inst",    out_inst, word_of(32'h00002000));
        chk("t7_pc_curr", fetch_output.fetch_pc_curr, 32'h00002000);
        chk("t7_pc_next", fetch_output.fetch_pc_next, 32'h00002004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
